// File: rtl/key_resp_pkg.sv
// key_resp_pkg: shared state encoding, framing widths and bus decode constants for the key response path.
// KEY_PARITY_EN adds one odd-parity bit per frame.
package key_resp_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
    localparam int BYTE_W = 8;
    localparam logic SSER_ACT = 1'b0;
    localparam logic BA13_SEL = 1'b0;
    localparam logic BA12_SEL = 1'b1;
`ifdef KEY_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = BYTE_W + PAR_W;

    function automatic logic [BYTE_W-1:0] rev_bits(input logic [BYTE_W-1:0] b);
        for (int i = 0; i < BYTE_W; i++) rev_bits[i] = b[BYTE_W-1-i];
    endfunction
endpackage

// File: rtl/key_resp_fifo.sv
// key_resp_fifo: synchronous FIFO with level, no fall-through; a push into a full FIFO only lands if a pop frees a slot.
module key_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o = cnt_q == (AW+1)'(DEPTH);
    assign do_pop = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o = empty_o ? '0 : mem_q[rd_q];
    assign level_o = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_q + AW'(do_push);
            rd_q <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/key_resp_deserializer.sv
// key_resp_deserializer: samples SDRD once per key read window, frames bytes and queues them for the host.
// Define KEY_PARITY_EN for 9-bit frames (odd parity) and the sticky parity_err output.
module key_resp_deserializer
    import key_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT = 255,
    parameter bit MSB_FIRST = 1'b1,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sser,
    input  logic          ba13,
    input  logic          ba12,
    input  logic          br_w,
    input  logic          sdrd,
    input  logic          clear,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow,
    output logic          timeout_err,
`ifdef KEY_PARITY_EN
    output logic          parity_err,
`endif
    output logic [LW-1:0] level
);
    state_e state_q;
    logic [3:0] bit_cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic [15:0] idle_q;
    logic win, win_q, edge_w, push, pop, full, empty, par_ok, overflow_q, tmo_q;
    logic [BYTE_W-1:0] raw;

    assign win = (sser == SSER_ACT) & (ba13 == BA13_SEL) & (ba12 == BA12_SEL) & br_w;
    assign edge_w = win & ~win_q;
    // first sampled bit sits at the top of the shifter
    assign raw = shift_q[FRAME_W-1 -: BYTE_W];
`ifdef KEY_PARITY_EN
    assign par_ok = ^shift_q;
`else
    assign par_ok = 1'b1;
`endif
    assign push = (state_q == COMMIT) & par_ok & ~clear;
    assign pop = out_valid & out_ready;
    assign out_valid = ~empty;
    assign overflow = overflow_q;
    assign timeout_err = tmo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bit_cnt_q <= '0;
            shift_q <= '0;
            win_q <= 1'b0;
            idle_q <= '0;
            overflow_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            win_q <= win;
            if (clear) begin
                state_q <= IDLE;
                bit_cnt_q <= '0;
                shift_q <= '0;
                idle_q <= '0;
                overflow_q <= 1'b0;
                tmo_q <= 1'b0;
            end else begin
                tmo_q <= 1'b0;
                overflow_q <= overflow_q | (push & full & ~pop);
                if (edge_w) begin
                    shift_q <= (state_q == SHIFT) ? {shift_q[FRAME_W-2:0], sdrd} : FRAME_W'(sdrd);
                    bit_cnt_q <= (state_q == SHIFT) ? bit_cnt_q + 4'd1 : 4'd1;
                    state_q <= (state_q == SHIFT && bit_cnt_q == 4'(FRAME_W - 1)) ? COMMIT : SHIFT;
                    idle_q <= '0;
                end else if (state_q == COMMIT) begin
                    state_q <= IDLE;
                    bit_cnt_q <= '0;
                    shift_q <= '0;
                end else if (state_q == SHIFT) begin
                    if (idle_q >= 16'(TIMEOUT - 1)) begin
                        tmo_q <= 1'b1;
                        state_q <= IDLE;
                        bit_cnt_q <= '0;
                        shift_q <= '0;
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_q + 16'd1;
                    end
                end
            end
        end
    end

`ifdef KEY_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else if (clear) perr_q <= 1'b0;
        else if (state_q == COMMIT && !par_ok) perr_q <= 1'b1;
    end
    assign parity_err = perr_q;
`endif

    key_resp_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clr_i(clear),
        .push_i(push),
        .pop_i(pop),
        .din_i(MSB_FIRST ? raw : rev_bits(raw)),
        .dout_o(out_data),
        .full_o(full),
        .empty_o(empty),
        .level_o(level)
    );
endmodule
